// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment capture path: glyph encodings
// (active-low, bit6=a .. bit0=g) and the capture FSM state type.
package seg_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_GLYPH_0 = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_GLYPH_1 = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_GLYPH_2 = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_GLYPH_3 = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_GLYPH_4 = 7'b1001100;
    localparam logic [SEG_W-1:0] SEG_GLYPH_5 = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_GLYPH_6 = 7'b0100000;
    localparam logic [SEG_W-1:0] SEG_GLYPH_7 = 7'b0001111;
    localparam logic [SEG_W-1:0] SEG_GLYPH_8 = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_GLYPH_9 = 7'b0000100;
    localparam logic [SEG_W-1:0] SEG_BLANK   = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HELD  = 2'd2
    } seg_state_e;

endpackage

// File: rtl/seg_to_bcd.sv
// Combinational inverse of the BCD-to-7-segment decoder: maps an active-low
// abcdefg pattern to BCD and flags whether it is one of the ten legal glyphs.
module seg_to_bcd
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic [3:0]       bcd,
    output logic             legal
);

    always_comb begin
        bcd   = 4'd0;
        legal = 1'b1;
        case (seg)
            SEG_GLYPH_0: bcd = 4'd0;
            SEG_GLYPH_1: bcd = 4'd1;
            SEG_GLYPH_2: bcd = 4'd2;
            SEG_GLYPH_3: bcd = 4'd3;
            SEG_GLYPH_4: bcd = 4'd4;
            SEG_GLYPH_5: bcd = 4'd5;
            SEG_GLYPH_6: bcd = 4'd6;
            SEG_GLYPH_7: bcd = 4'd7;
            SEG_GLYPH_8: bcd = 4'd8;
            SEG_GLYPH_9: bcd = 4'd9;
            default:     legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Samples a multiplexed active-low 7-segment bus, debounces each scanned digit
// and rebuilds the displayed BCD digits with frame-complete and error flags.
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4,
    parameter int STABLE_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SEG_W-1:0]        seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    input  logic                    clr_err,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_done,
    output logic                    err_pattern,
    output logic                    err_anode
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int LOW_W = $clog2(NUM_DIGITS + 1);
    localparam logic [STABLE_W-1:0] CNT_TOP = STABLE_W'(STABLE_CYCLES);

    // Sample stage
    logic [SEG_W-1:0]      smp_seg;
    logic [NUM_DIGITS-1:0] smp_an;
    logic                  smp_vld;

    // Anode qualification
    logic [LOW_W-1:0]      low_cnt;
    logic [IDX_W-1:0]      act_idx;
    logic                  act;
    logic                  illegal;

    // FSM / stability tracking
    seg_state_e            state, state_nxt;
    logic [STABLE_W-1:0]   cnt, cnt_nxt;
    logic [IDX_W-1:0]      ref_idx;
    logic [SEG_W-1:0]      ref_seg;
    logic                  match;
    logic                  load;
    logic                  commit;

    logic [3:0]            dec_bcd;
    logic                  dec_legal;
    logic [NUM_DIGITS-1:0] seen, seen_set;

    // smp_vld keeps the all-zero reset value of the sample registers from
    // being read as an all-anodes-low bus in the first cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            smp_seg <= '0;
            smp_an  <= '0;
            smp_vld <= 1'b0;
        end else begin
            smp_seg <= seg_n;
            smp_an  <= an_n;
            smp_vld <= 1'b1;
        end
    end

    always_comb begin
        low_cnt = '0;
        act_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!smp_an[i]) begin
                low_cnt = low_cnt + LOW_W'(1);
                act_idx = IDX_W'(i);
            end
        end
        act     = smp_vld && (low_cnt == LOW_W'(1));
        illegal = smp_vld && (low_cnt > LOW_W'(1));
        match   = (ref_idx == act_idx) && (ref_seg == smp_seg);
    end

    seg_to_bcd u_dec (
        .seg   (smp_seg),
        .bcd   (dec_bcd),
        .legal (dec_legal)
    );

    // Next-state decode; a commit is the step that brings cnt to the target.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (act) begin
                    load      = 1'b1;
                    cnt_nxt   = STABLE_W'(1);
                    state_nxt = TRACK;
                end
            end
            TRACK: begin
                if (!act) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (match) begin
                    cnt_nxt = (cnt >= CNT_TOP) ? CNT_TOP : cnt + STABLE_W'(1);
                end else begin
                    load    = 1'b1;
                    cnt_nxt = STABLE_W'(1);
                end
            end
            HELD: begin
                if (!act) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (!match) begin
                    load      = 1'b1;
                    cnt_nxt   = STABLE_W'(1);
                    state_nxt = TRACK;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
        commit = act && (state_nxt == TRACK) && (cnt_nxt >= CNT_TOP);
        if (commit) begin
            state_nxt = HELD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ref_idx <= '0;
            ref_seg <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load) begin
                ref_idx <= act_idx;
                ref_seg <= smp_seg;
            end
        end
    end

    always_comb begin
        seen_set = seen;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == act_idx) begin
                seen_set[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digits      <= '0;
            digit_valid <= '0;
            seen        <= '0;
            frame_done  <= 1'b0;
            err_pattern <= 1'b0;
            err_anode   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (commit) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (IDX_W'(i) == act_idx) begin
                        if (dec_legal) begin
                            digits[4*i +: 4] <= dec_bcd;
                        end
                        digit_valid[i] <= dec_legal;
                    end
                end
                if (&seen_set) begin
                    seen       <= '0;
                    frame_done <= 1'b1;
                end else begin
                    seen <= seen_set;
                end
            end
            // A new error event in the same cycle as clr_err keeps the flag set.
            err_pattern <= (err_pattern & ~clr_err) | (commit & ~dec_legal);
            err_anode   <= (err_anode & ~clr_err) | illegal;
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: drives scanned glyph sequences and
// checks captured digits, valid bits, frame pulses and sticky errors.
module tb_seg_scan_capture;

    localparam logic [6:0] G0 = 7'b0000001;
    localparam logic [6:0] G1 = 7'b1001111;
    localparam logic [6:0] G2 = 7'b0010010;
    localparam logic [6:0] G3 = 7'b0000110;
    localparam logic [6:0] G4 = 7'b1001100;
    localparam logic [6:0] G5 = 7'b0100100;
    localparam logic [6:0] G6 = 7'b0100000;
    localparam logic [6:0] G7 = 7'b0001111;
    localparam logic [6:0] G8 = 7'b0000000;
    localparam logic [6:0] G9 = 7'b0000100;
    localparam logic [6:0] GB = 7'b1111111;

    logic        clk;
    logic        rst;
    logic [6:0]  seg_n;
    logic [5:0]  an_n;
    logic        clr_err;
    logic [23:0] digits;
    logic [5:0]  digit_valid;
    logic        frame_done;
    logic        err_pattern;
    logic        err_anode;

    int checks;
    int errors;
    int fd_cnt;

    logic [6:0] scan_glyph [6];

    seg_scan_capture #(
        .NUM_DIGITS    (6),
        .STABLE_CYCLES (4),
        .STABLE_W      (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .clr_err     (clr_err),
        .digits      (digits),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .err_pattern (err_pattern),
        .err_anode   (err_anode)
    );

    // Clock and frame_done pulse monitor
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] an, input logic [6:0] seg);
        an_n  = an;
        seg_n = seg;
    endtask

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        fd_cnt  = 0;
        rst     = 1'b1;
        clr_err = 1'b0;
        drive(6'b111111, GB);
        tick(3);
        rst = 1'b0;
        check("reset_digits", digits, 24'h000000);
        check("reset_valid", 24'(digit_valid), 24'h0);
        check("reset_errs", {22'd0, err_pattern, err_anode}, 24'h0);
        check("reset_frame", 24'(frame_done), 24'h0);

        // Single digit latency
        drive(6'b111110, G2);
        tick(4);
        check("lat_before_valid", 24'(digit_valid), 24'h0);
        check("lat_before_digits", digits, 24'h000000);
        tick(1);
        check("lat_digits", digits, 24'h000002);
        check("lat_valid", 24'(digit_valid), 24'h01);
        check("lat_no_frame", 24'(fd_cnt), 24'd0);
        drive(6'b111111, GB);
        tick(3);

        // Full scan 1,2,3,4,5,9
        scan_glyph[0] = G1; scan_glyph[1] = G2; scan_glyph[2] = G3;
        scan_glyph[3] = G4; scan_glyph[4] = G5; scan_glyph[5] = G9;
        fd_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            drive(~(6'b000001 << i), scan_glyph[i]);
            tick(6);
            drive(6'b111111, GB);
            tick(1);
        end
        check("scan_no_early_frame", 24'(fd_cnt), 24'd0);
        drive(6'b011111, scan_glyph[5]);
        tick(5);
        check("scan_frame_pulse", 24'(frame_done), 24'h1);
        tick(1);
        check("scan_frame_one_cycle", 24'(frame_done), 24'h0);
        drive(6'b111111, GB);
        tick(2);
        check("scan_digits", digits, 24'h954321);
        check("scan_valid", 24'(digit_valid), 24'h3f);
        check("scan_frame_count", 24'(fd_cnt), 24'd1);

        // Short 8 on digit 2 must not commit; following 6 does
        drive(6'b111011, G8);
        tick(3);
        drive(6'b111011, G6);
        tick(4);
        check("glitch_no_commit", 24'(digits[11:8]), 24'h3);
        drive(6'b111111, GB);
        tick(1);
        check("glitch_commit6", digits, 24'h954621);
        tick(2);

        // Double anode forces IDLE and sets err_anode
        drive(6'b111110, G7);
        tick(2);
        drive(6'b111100, G7);
        tick(1);
        drive(6'b111110, G7);
        tick(1);
        check("anode_err_set", 24'(err_anode), 24'h1);
        tick(3);
        check("anode_restart_count", 24'(digits[3:0]), 24'h1);
        tick(1);
        check("anode_commit7", digits, 24'h954627);
        drive(6'b111111, GB);
        tick(2);

        // clr_err against a simultaneous double-anode event, then alone
        drive(6'b111100, GB);
        tick(1);
        drive(6'b111111, GB);
        clr_err = 1'b1;
        tick(1);
        check("clr_vs_set", 24'(err_anode), 24'h1);
        tick(1);
        check("clr_alone", 24'(err_anode), 24'h0);
        clr_err = 1'b0;

        // Blank glyph on digit 3
        drive(6'b110111, GB);
        tick(4);
        drive(6'b111111, GB);
        tick(1);
        check("pat_err", 24'(err_pattern), 24'h1);
        check("pat_valid", 24'(digit_valid), 24'h37);
        check("pat_digits_kept", digits, 24'h954627);
        tick(1);

        // seen already holds 0,2,3; finishing 1,4,5 closes one frame
        fd_cnt = 0;
        drive(6'b111101, G0); tick(6); drive(6'b111111, GB); tick(1);
        drive(6'b101111, G6); tick(6); drive(6'b111111, GB); tick(1);
        check("seen_no_frame_yet", 24'(fd_cnt), 24'd0);
        drive(6'b011111, G8); tick(6); drive(6'b111111, GB); tick(1);
        check("seen_frame", 24'(fd_cnt), 24'd1);
        check("seen_digits", digits, 24'h864607);
        check("seen_valid", 24'(digit_valid), 24'h37);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("pat_clr", 24'(err_pattern), 24'h0);

        // Reset in the middle of a stability count
        drive(6'b111101, G8);
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_digits", digits, 24'h000000);
        check("rst_flags", {16'd0, digit_valid, err_pattern, err_anode}, 24'h0);
        tick(4);
        check("rst_full_count", 24'(digit_valid), 24'h0);
        tick(1);
        check("rst_commit_digits", digits, 24'h000080);
        check("rst_commit_valid", 24'(digit_valid), 24'h02);
        check("rst_no_anode_err", 24'(err_anode), 24'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
